// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator datapath.
// Op encoding, accumulator FSM states and data width.
package calc_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/Mux2_8b_GL.sv
// Mux2_8b_GL: 8-bit 2:1 mux, y = sel ? b : a.
// Shared calculator building block.
module Mux2_8b_GL (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  output logic [7:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/accum_alu_8b.sv
// accum_alu_8b: combinational 8-bit add/subtract.
// cy is carry-out on add, borrow on subtract.
module accum_alu_8b
  import calc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cy
);

  logic [DATA_W:0] ext_a;
  logic [DATA_W:0] ext_b;

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};

  always_comb begin
    {cy, sum} = sub ? (ext_a - ext_b)
                    : (ext_a + ext_b);
  end

endmodule

// File: rtl/calc_accum_8b.sv
// calc_accum_8b: multi-cycle load/add/sub/mul accumulator.
// Define CALC_ACCUM_SAT_EN for saturating results.
module calc_accum_8b
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);

  state_t            state;
  state_t            state_nxt;
  op_t               op;
  logic [DATA_W-1:0] acc;
  logic              ovf;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [15:0]       prod;
  logic [15:0]       prod_step;
  logic [15:0]       addend;
  logic [2:0]        cnt;
  logic              accept;
  logic              is_sub;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_cy;
  logic [DATA_W-1:0] arith;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] mul_res;
  logic              mul_ovf;
  logic              last_step;

  assign op        = op_t'(in_op);
  assign in_rdy    = (state == ST_IDLE);
  assign out_val   = (state == ST_DONE);
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign accept    = in_val && in_rdy;
  assign is_sub    = (op == OP_SUB);
  assign last_step = (cnt == 3'd7);

  accum_alu_8b u_alu (
    .a   (acc),
    .b   (in_data),
    .sub (is_sub),
    .sum (alu_sum),
    .cy  (alu_cy)
  );

  assign addend = mplier[cnt]
                ? ({8'h00, mcand} << cnt)
                : 16'h0000;
  assign prod_step = prod + addend;
  assign mul_ovf   = |prod_step[15:8];

`ifdef CALC_ACCUM_SAT_EN
  // Clamp toward the side the result escaped from.
  assign arith   = !alu_cy ? alu_sum
                 : (is_sub ? 8'h00 : 8'hFF);
  assign mul_res = mul_ovf ? 8'hFF
                           : prod_step[7:0];
`else
  assign arith   = alu_sum;
  assign mul_res = prod_step[7:0];
`endif

  Mux2_8b_GL u_mux (
    .a   (arith),
    .b   (in_data),
    .sel (op == OP_LOAD),
    .y   (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (accept)
          state_nxt = (op == OP_MUL)
                    ? ST_CALC : ST_DONE;
      end
      state == ST_CALC: begin
        if (last_step)
          state_nxt = ST_DONE;
      end
      state == ST_DONE: begin
        if (out_rdy)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && accept) begin
        if (op == OP_MUL) begin
          mcand  <= acc;
          mplier <= in_data;
          prod   <= '0;
          cnt    <= '0;
        end else begin
          acc <= acc_nxt;
          ovf <= alu_cy && (op != OP_LOAD);
        end
      end
      if (state == ST_CALC) begin
        prod <= prod_step;
        cnt  <= cnt + 3'd1;
        if (last_step) begin
          acc <= mul_res;
          ovf <= mul_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_accum_8b.sv
// tb_calc_accum_8b: directed and random checks for calc_accum_8b.
// Honours CALC_ACCUM_SAT_EN for expected results.
module tb_calc_accum_8b;

`ifdef CALC_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_data;
  logic       out_ovf;

  int checks = 0;
  int failures = 0;

  int m_acc;
  bit m_ovf;

  calc_accum_8b dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_op    (in_op),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op for a single cycle; returns in the cycle after accept.
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    in_val  = 1'b1;
    in_op   = op;
    in_data = d;
    tick();
    in_val  = 1'b0;
    in_data = 8'h5A;
    in_op   = 2'b00;
  endtask

  // cyc counts cycles since accept; 1 on entry.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_val && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pop();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 ||
        out_data !== 8'h00 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state rdy=%b val=%b data=%h ovf=%b req 1 0 00 0",
               in_rdy, out_val, out_data, out_ovf);
    end
  endtask

  task automatic test_add();
    logic [7:0] exp_d;
    issue(2'b00, 8'hF0);
    checks++;
    if (out_val !== 1'b1 || out_data !== 8'hF0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL load_f0 val=%b data=%h ovf=%b req 1 f0 0",
               out_val, out_data, out_ovf);
    end
    pop();
    issue(2'b01, 8'h20);
    exp_d = SAT ? 8'hFF : 8'h10;
    checks++;
    if (out_val !== 1'b1 || out_data !== exp_d || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf val=%b data=%h ovf=%b req 1 %h 1",
               out_val, out_data, out_ovf, exp_d);
    end
    pop();
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      failures++;
      $display("FAIL add_ret_idle rdy=%b val=%b req 1 0",
               in_rdy, out_val);
    end
  endtask

  task automatic test_sub_hold();
    logic [7:0] exp_d;
    issue(2'b00, 8'h05);
    pop();
    issue(2'b10, 8'h07);
    exp_d = SAT ? 8'h00 : 8'hFE;
    checks++;
    if (out_val !== 1'b1 || out_data !== exp_d || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sub_borrow val=%b data=%h ovf=%b req 1 %h 1",
               out_val, out_data, out_ovf, exp_d);
    end
    for (int i = 0; i < 3; i++) begin
      in_val  = (i != 1);
      in_op   = 2'b00;
      in_data = 8'h55;
      tick();
      checks++;
      if (out_val !== 1'b1 || in_rdy !== 1'b0 ||
          out_data !== exp_d || out_ovf !== 1'b1) begin
        failures++;
        $display("FAIL sub_hold%0d val=%b rdy=%b data=%h ovf=%b req 1 0 %h 1",
                 i, out_val, in_rdy, out_data, out_ovf, exp_d);
      end
    end
    in_val = 1'b0;
    pop();
    checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1 || out_data !== exp_d) begin
      failures++;
      $display("FAIL sub_release val=%b rdy=%b data=%h req 0 1 %h",
               out_val, in_rdy, out_data, exp_d);
    end
  endtask

  task automatic test_mul();
    int cyc;
    logic [7:0] exp_d;
    issue(2'b00, 8'h0C);
    pop();
    issue(2'b11, 8'h0B);
    in_data = 8'hFF;
    in_op   = 2'b01;
    wait_done(cyc);
    checks++;
    if (cyc !== 9) begin
      failures++;
      $display("FAIL mul_latency cycles=%0d req 9", cyc);
    end
    checks++;
    if (out_data !== 8'h84 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL mul_0c_0b data=%h ovf=%b req 84 0",
               out_data, out_ovf);
    end
    pop();
    issue(2'b00, 8'h20);
    pop();
    issue(2'b11, 8'h10);
    wait_done(cyc);
    exp_d = SAT ? 8'hFF : 8'h00;
    checks++;
    if (cyc !== 9 || out_data !== exp_d || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL mul_ovf cycles=%0d data=%h ovf=%b req 9 %h 1",
               cyc, out_data, out_ovf, exp_d);
    end
    pop();
  endtask

  task automatic test_reset_mid_calc();
    issue(2'b00, 8'h07);
    pop();
    issue(2'b11, 8'h09);
    tick();
    tick();
    tick();
    reset   = 1'b1;
    in_val  = 1'b1;
    out_rdy = 1'b1;
    tick();
    reset   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 ||
        out_data !== 8'h00 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_calc rdy=%b val=%b data=%h ovf=%b req 1 0 00 0",
               in_rdy, out_val, out_data, out_ovf);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (out_val !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_result val=%b req 0", out_val);
    end
    issue(2'b01, 8'h03);
    checks++;
    if (out_val !== 1'b1 || out_data !== 8'h03 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_after_reset val=%b data=%h ovf=%b req 1 03 0",
               out_val, out_data, out_ovf);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 8'h10);
    pop();
    issue(2'b01, 8'h22);
    pop();
    issue(2'b10, 8'h02);
    checks++;
    if (out_data !== 8'h30 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back data=%h ovf=%b req 30 0",
               out_data, out_ovf);
    end
    pop();
  endtask

  task automatic test_random();
    int cyc;
    int r;
    int stall;
    logic [1:0] op;
    logic [7:0] d;
    m_acc = 8'h30;
    m_ovf = 1'b0;
    for (int n = 0; n < 50; n++) begin
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      case (op)
        2'b00: begin
          m_acc = d;
          m_ovf = 1'b0;
        end
        2'b01: begin
          r = m_acc + d;
          m_ovf = (r > 255);
          m_acc = m_ovf ? (SAT ? 255 : r - 256) : r;
        end
        2'b10: begin
          r = m_acc - d;
          m_ovf = (r < 0);
          m_acc = m_ovf ? (SAT ? 0 : r + 256) : r;
        end
        default: begin
          r = m_acc * d;
          m_ovf = (r > 255);
          m_acc = m_ovf ? (SAT ? 255 : r % 256) : r;
        end
      endcase
      issue(op, d);
      wait_done(cyc);
      checks++;
      if (out_val !== 1'b1 || out_data !== 8'(m_acc) || out_ovf !== m_ovf) begin
        failures++;
        $display("FAIL rand%0d op=%0d d=%h val=%b data=%h ovf=%b req 1 %h %b",
                 n, op, d, out_val, out_data, out_ovf, 8'(m_acc), m_ovf);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) tick();
      pop();
    end
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = 1'b0;
    in_op   = 2'b00;
    in_data = 8'h00;
    out_rdy = 1'b0;
    test_reset();
    test_add();
    test_sub_hold();
    test_mul();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
